// File: rtl/child_checker.sv
// Stimulus/check engine for the block Result = a & (b | c): walks all eight input
// combinations, samples result_in after a settle time and records mismatches.
// Optional build macro CHILD_CHECKER_STOP_ON_ERR_EN ends a run at its first mismatch.
module child_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    input  logic                 result_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [7:0]           fail_vec
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t               state;
    logic [2:0]           idx;
    logic [3:0]           cnt;
    logic                 expected;
    logic                 mismatch;
    logic [ERR_CNT_W-1:0] err_next;

    // The driven vector is the index itself, so a/b/c are registered bits of idx.
    assign a = idx[2];
    assign b = idx[1];
    assign c = idx[0];

    assign expected = a & (b | c);
    assign mismatch = (result_in != expected);
    assign err_next = (&err_count) ? err_count : err_count + ERR_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= 3'd0;
                        cnt       <= SETTLE;
                        err_count <= '0;
                        fail_vec  <= 8'h00;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (mismatch) begin
                            fail_vec[idx] <= 1'b1;
                            err_count     <= err_next;
                        end
`ifdef CHILD_CHECKER_STOP_ON_ERR_EN
                        if (mismatch) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b0;
                        end else
`endif
                        if (idx != 3'd7) begin
                            idx <= idx + 3'd1;
                            cnt <= SETTLE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // err_count has not yet absorbed a mismatch on the last vector
                            pass  <= (err_count == '0) && !mismatch;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_child_checker.sv
// Randomized self-checking bench for child_checker against a time-based reference model.
module tb_child_checker;
    localparam int S = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic res = 1'b0;
    logic res0 = 1'b0;
    logic a, b, c, busy, done, pass;
    logic [3:0] err;
    logic [7:0] fv;
    logic a0, b0, c0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [7:0] fv0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mode = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    child_checker #(.SETTLE_CYCLES(S), .ERR_CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
        .result_in(res), .busy(busy), .done(done), .pass(pass),
        .err_count(err), .fail_vec(fv)
    );

    child_checker #(.SETTLE_CYCLES(0), .ERR_CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a0), .b(b0), .c(c0),
        .result_in(res0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fv0)
    );

    // Block under check: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 random
    always @(negedge clk) begin
        case (mode)
            0:       res = a & (b | c);
            1:       res = 1'b0;
            2:       res = 1'b1;
            default: res = 1'($urandom % 2);
        endcase
        res0 = a0 & (b0 | c0);
    end

    // Reference model: run position derived from elapsed edges since start
    bit         m_run;
    int         m_t;
    logic [2:0] m_abc;
    logic       m_busy, m_done, m_pass;
    int         m_err;
    logic [7:0] m_fv;

    always @(posedge clk) begin
        int   k;
        logic e;
        bit   fin;
        cyc++;
        if (rst) begin
            m_run = 0; m_t = 0; m_abc = 3'd0; m_busy = 0; m_done = 0;
            m_pass = 0; m_err = 0; m_fv = 8'h00;
            chk_en = 1'b1;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (start) begin
                    m_run = 1; m_t = 0; m_abc = 3'd0; m_err = 0;
                    m_fv = 8'h00; m_pass = 0; m_busy = 1;
                end
            end else begin
                m_t++;
                if (m_t % (S + 1) == 0) begin
                    k = m_t / (S + 1) - 1;
                    e = k[2] & (k[1] | k[0]);
                    if (res !== e) begin
                        m_fv[k] = 1'b1;
                        if (m_err < 15) m_err++;
                    end
`ifdef CHILD_CHECKER_STOP_ON_ERR_EN
                    fin = (k == 7) || (res !== e);
`else
                    fin = (k == 7);
`endif
                    if (fin) begin
                        m_run = 0; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                    end else begin
                        m_abc = 3'(k + 1);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("abc",       32'({a, b, c}), 32'(m_abc));
            check("busy",      32'(busy),      32'(m_busy));
            check("done",      32'(done),      32'(m_done));
            check("pass",      32'(pass),      32'(m_pass));
            check("err_count", 32'(err),       32'(m_err));
            check("fail_vec",  32'(fv),        32'(m_fv));
        end
    end

    task automatic pulse_start(output int t);
        @(negedge clk);
        start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int t);
        bit seen;
        seen = 0;
        t = -1;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                t = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", limit);
        end
    endtask

    initial begin
        int ts, td, seen;
        mode = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_abc",  32'({a, b, c}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err",  32'(err), 32'd0);
        check("rst_fv",   32'(fv), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Correct block; the SETTLE=0 instance steps one vector per cycle
        pulse_start(ts);
        check("s0_abc_0", 32'({a0, b0, c0}), 32'd0);
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            check("s0_abc_step", 32'({a0, b0, c0}), 32'(j));
        end
        @(negedge clk);
        check("s0_done", 32'(done0), 32'd1);
        check("s0_done_edge", 32'(cyc - ts), 32'd8);
        check("s0_pass", 32'(pass0), 32'd1);
        wait_done(40, td);
        check("good_done_edge", 32'(td - ts), 32'd16);
        check("good_pass", 32'(pass), 32'd1);
        check("good_err", 32'(err), 32'd0);
        check("good_fv", 32'(fv), 32'h00);

        mode = 1;
        pulse_start(ts);
        wait_done(40, td);
`ifndef CHILD_CHECKER_STOP_ON_ERR_EN
        check("stuck0_fv", 32'(fv), 32'hE0);
        check("stuck0_err", 32'(err), 32'd3);
`endif
        check("stuck0_pass", 32'(pass), 32'd0);

        mode = 2;
        pulse_start(ts);
        wait_done(40, td);
`ifdef CHILD_CHECKER_STOP_ON_ERR_EN
        check("stuck1_done_edge", 32'(td - ts), 32'(S + 1));
        check("stuck1_fv", 32'(fv), 32'h01);
        check("stuck1_err", 32'(err), 32'd1);
        check("stuck1_abc", 32'({a, b, c}), 32'd0);
`else
        check("stuck1_done_edge", 32'(td - ts), 32'd16);
        check("stuck1_fv", 32'(fv), 32'h1F);
        check("stuck1_err", 32'(err), 32'd5);
        check("stuck1_abc", 32'({a, b, c}), 32'd7);
`endif
        check("stuck1_pass", 32'(pass), 32'd0);

        // Start again at edge 5 of a run is ignored
        mode = 0;
        pulse_start(ts);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, td);
        check("restart_ignored_edge", 32'(td - ts), 32'd16);
        check("restart_ignored_pass", 32'(pass), 32'd1);

        // Start while done is high is accepted
        mode = 3;
        start = 1'b1;
        ts = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(40, td);
        check("b2b_done_edge", 32'(td - ts), 32'd16);

        // Reset at edge 6 of a run
        mode = 0;
        pulse_start(ts);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_abc", 32'({a, b, c}), 32'd0);
        check("midrst_fv", 32'(fv), 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        pulse_start(ts);
        wait_done(40, td);
        check("midrst_fresh_pass", 32'(pass), 32'd1);

        // Randomized runs with stray start pulses
        for (int r = 0; r < 16; r++) begin
            mode = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_start(ts);
            if ($urandom % 2 == 1) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done(40, td);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/child_checker.md
Name: child_checker

Overview:
- Sequential stimulus/check engine for the 3-input logic block Result = a & (b | c). It is the driving end of that block's interface: it drives a, b and c, then samples Result.
- On a start pulse it walks all 8 input combinations. For each one it waits a programmable settle time, compares the sampled Result against the expected value, and accumulates mismatches.
- Used in the dependence test area as a self-checking harness and as a built-in self-test wrapper.

Parameters:
- SETTLE_CYCLES, default 1: idle cycles between driving a vector and sampling result_in. Legal range 0..15.
- ERR_CNT_W, default 4: width of err_count. Minimum 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request; honoured only when busy=0
- a  output  1  stimulus bit, equals idx[2]
- b  output  1  stimulus bit, equals idx[1]
- c  output  1  stimulus bit, equals idx[0]
- result_in  input  1  Result from the block under check
- busy  output  1  high from the start-accept edge until the final sample edge
- done  output  1  one-cycle pulse after the final sample
- pass  output  1  1 when the last completed run had zero mismatches; held until the next start
- err_count  output  ERR_CNT_W  number of mismatches in the current/last run, saturating
- fail_vec  output  8  bit i set when combination i mismatched

Behaviour:
- Reset (rst=1 at a clock edge):
  - Outputs: a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
  - Internal: state=IDLE, idx=0, settle counter=0.
  - Reset dominates start.
- States: IDLE, RUN.
- IDLE + start=1 (start edge):
  - idx<=0, {a,b,c}<=3'b000, cnt<=SETTLE_CYCLES.
  - err_count<=0, fail_vec<=0, pass<=0, busy<=1, state<=RUN.
- IDLE + start=0: hold all outputs; done=0.
- RUN, cnt!=0: cnt<=cnt-1; no sample.
- RUN, cnt==0 (sample edge):
  - exp = a & (b | c), computed from the registered a, b, c.
  - If result_in!=exp:
    - fail_vec[idx]<=1.
    - err_count<=err_count+1, saturating at all-ones.
  - If idx!=7:
    - idx<=idx+1 and {a,b,c}<=idx+1.
    - cnt<=SETTLE_CYCLES; stay in RUN.
  - If idx==7:
    - state<=IDLE, busy<=0, done<=1 for exactly one cycle.
    - pass<=(final err_count==0), including a mismatch at idx 7.
    - a, b, c hold 1,1,1 until the next start.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done rises 8*(SETTLE_CYCLES+1) edges after the start edge (16 at the default).
  - result_in is sampled combinationally at the sample edge. No input register.
- start while busy=1: ignored; no restart, no effect on counters.
- start in the same cycle that done is high: accepted, and the new run begins.
- Reset mid-run: abort immediately to reset values; no done pulse.
- Results persist in IDLE: fail_vec, err_count and pass keep the last run's values.

Optional Feature:
- Macro: CHILD_CHECKER_STOP_ON_ERR_EN.
- When defined, the first mismatch ends the run at that sample edge:
  - fail_vec bit and err_count=1 are recorded.
  - state<=IDLE, busy<=0, done pulses, pass<=0.
  - a, b, c hold the failing vector.
- When undefined, all 8 combinations are always checked as described above.

Test Plan:
- Correct model (result_in = a&(b|c)), SETTLE_CYCLES=1, start pulse at cycle 0:
  - done at edge 16.
  - pass=1, err_count=0, fail_vec=8'h00, busy high for cycles 1..16.
- result_in stuck at 0 → fail_vec=8'hE0, err_count=3, pass=0.
- result_in stuck at 1 → fail_vec=8'h1F, err_count=5, pass=0.
- SETTLE_CYCLES=0, correct model:
  - a,b,c step 000→111 on consecutive cycles.
  - done at edge 8.
- Start pulse again at edge 5 of a run → ignored; done still at edge 16.
- rst at edge 6, then start → outputs return to reset values, no done pulse, and the fresh run passes.
- With CHILD_CHECKER_STOP_ON_ERR_EN and result_in stuck at 1:
  - done at edge SETTLE_CYCLES+1.
  - fail_vec=8'h01, err_count=1, {a,b,c}=000, pass=0.
